vec_alu_seq: RTL and testbench
==============================

Name: vec_alu_seq

Overview:
- Sequential vector execute stage between the vector register file read ports (rd1/rd2) and its write port (wd3/ra3/we3).
- Takes two packed vectors of signed Q1.7 lanes and an opcode, processes LANESPERCYCLE lanes per cycle, then holds the packed result until writeback accepts it.
- Opcodes: saturating add, subtract, multiply, and a dot-product reduction used for FIR tap accumulation.

Parameters:
- VECTORSPERREG, 16, lanes per vector.
- DATAWIDTH, 8, bits per lane (signed Q1.7).
- REGSIZEINT, 5, destination register address width.
- LANESPERCYCLE, 4, lanes processed per compute cycle; must divide VECTORSPERREG.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  2  00 VADD, 01 VSUB, 10 VMUL, 11 VDOT.
- dst  in  REGSIZEINT  destination vector register.
- srca  in  VECTORSPERREG*DATAWIDTH  operand A; lane i at bits [8i+7:8i].
- srcb  in  VECTORSPERREG*DATAWIDTH  operand B; same lane mapping.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts result.
- wd3  out  VECTORSPERREG*DATAWIDTH  packed result, same lane mapping.
- ra3  out  REGSIZEINT  captured dst.
- we3  out  1  out_valid & out_ready (combinational).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; out_valid=0; wd3=0; ra3=0; accumulator=0; lane counter=0.
  - in_ready=1 in the cycle after reset.
  - Reset overrides any in-flight operation or held result; nothing is written back.
- States: IDLE, COMPUTE, DONE.
  - IDLE: in_ready=1. On an edge with in_valid=1, capture op, dst, srca and srcb, clear the accumulator and lane counter, and go to COMPUTE. With in_valid=0, stay in IDLE.
  - COMPUTE: in_ready=0. Each edge processes lanes [k*LANESPERCYCLE, (k+1)*LANESPERCYCLE-1] and increments k. After the edge that processes the final group (k = VECTORSPERREG/LANESPERCYCLE-1), go to DONE. This takes 4 edges at the defaults.
  - DONE: out_valid=1. wd3 and ra3 are stable and held while out_ready=0 (no timeout). On an edge with out_ready=1, go to IDLE and set out_valid=0.
- Inputs are sampled only at the accept edge; later changes to srca, srcb, op or dst do not affect the result.
- Latency: request accepted at edge T; out_valid=1 from edge T+4 (defaults). Minimum initiation interval is 6 cycles.
- in_ready is never high in the same cycle as out_valid. A new request presented while out_valid=1 waits.
- Arithmetic (signed 8-bit lanes; sat8 clamps to [-128, 127]):
  - VADD: lane = sat8(a+b), computed at 9 bits.
  - VSUB: lane = sat8(a-b), computed at 9 bits.
  - VMUL: lane = sat8((a*b) >>> 7), arithmetic shift with truncation toward -inf. -128*-128 saturates to 127.
  - VDOT: signed 20-bit accumulator (no overflow possible over 16 lanes) sums a*b for every lane. Final result = sat8(acc >>> 7), placed in lane 0; lanes 1..15 are 0.
- Lane results for VADD, VSUB and VMUL are written into a result register group by group. Lanes not yet computed hold 0 from the accept edge.

Test Plan:
- Reset, then idle → out_valid=0, in_ready=1, we3=0, wd3=0. Assert rst in the middle of COMPUTE → IDLE next cycle, no we3 pulse.
- VADD, all lanes a=0x7F b=0x01, dst=3, out_ready=1 → out_valid exactly 4 cycles after accept; wd3 all lanes 0x7F; ra3=3; we3 pulses for 1 cycle.
- VSUB, lane0 a=0x80 b=0x01, lane1 a=0x10 b=0x20, other lanes 0 → lane0=0x80 (saturated), lane1=0xF0, rest 0x00.
- VMUL, lane0 0x40*0x40, lane1 0x80*0x80, lane2 0xC0*0x40 → lane0=0x20, lane1=0x7F, lane2=0xE0.
- VDOT, all lanes a=0x40 b=0x40 (acc=65536) → lane0=0x7F (saturated), other lanes 0. All lanes a=0x08 b=0x08 → acc=1024, lane0=0x08.
- Backpressure: hold out_ready=0 for 10 cycles and change srca/op mid-compute → out_valid stays 1, wd3 unchanged, in_ready=0. Raise out_ready → one we3 pulse, then in_ready=1 next cycle. A back-to-back second op also completes correctly.

Source files
------------

// File: rtl/vec_alu_seq.sv
// Sequential vector execute stage: saturating Q1.7 add/sub/mul and a dot-product
// reduction, LANESPERCYCLE lanes per cycle, result held until writeback accepts it.
module vec_alu_seq #(
    parameter int unsigned VECTORSPERREG = 16,
    parameter int unsigned DATAWIDTH     = 8,
    parameter int unsigned REGSIZEINT    = 5,
    parameter int unsigned LANESPERCYCLE = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [1:0]                         op,
    input  logic [REGSIZEINT-1:0]              dst,
    input  logic [VECTORSPERREG*DATAWIDTH-1:0] srca,
    input  logic [VECTORSPERREG*DATAWIDTH-1:0] srcb,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [VECTORSPERREG*DATAWIDTH-1:0] wd3,
    output logic [REGSIZEINT-1:0]              ra3,
    output logic                               we3
);

    localparam int unsigned VW      = VECTORSPERREG * DATAWIDTH;
    localparam int unsigned NGROUPS = VECTORSPERREG / LANESPERCYCLE;
    localparam int unsigned KW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    // Wide enough for a full-vector sum of products without overflow.
    localparam int unsigned ACCW    = 2 * DATAWIDTH + $clog2(VECTORSPERREG);

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DATAWIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [KW-1:0]          K_LAST  = KW'(NGROUPS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpMul = 2'b10,
        OpDot = 2'b11
    } op_e;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [REGSIZEINT-1:0]   dst_q, dst_d;
    logic [VW-1:0]           a_q, a_d;
    logic [VW-1:0]           b_q, b_d;
    logic [VW-1:0]           res_q, res_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    out_valid_q, out_valid_d;

    function automatic logic [DATAWIDTH-1:0] sat_lane(input logic signed [ACCW-1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[DATAWIDTH-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[DATAWIDTH-1:0];
        end
        return x[DATAWIDTH-1:0];
    endfunction

    // Next-state: accept in IDLE, one lane group per cycle in COMPUTE, hold in DONE.
    always_comb begin
        logic signed [DATAWIDTH-1:0] la8;
        logic signed [DATAWIDTH-1:0] lb8;
        logic signed [ACCW-1:0]      la;
        logic signed [ACCW-1:0]      lb;
        logic signed [ACCW-1:0]      prod;
        logic signed [ACCW-1:0]      dot_sum;
        logic signed [ACCW-1:0]      acc_sum;
        int unsigned                 idx;

        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        acc_d       = acc_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        la8         = '0;
        lb8         = '0;
        la          = '0;
        lb          = '0;
        prod        = '0;
        dot_sum     = '0;
        acc_sum     = '0;
        idx         = 0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StCompute;
                    op_d    = op_e'(op);
                    dst_d   = dst;
                    a_d     = srca;
                    b_d     = srcb;
                    res_d   = '0;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            StCompute: begin
                for (int unsigned j = 0; j < LANESPERCYCLE; j++) begin
                    idx  = int'(k_q) * LANESPERCYCLE + j;
                    la8  = a_q[idx*DATAWIDTH +: DATAWIDTH];
                    lb8  = b_q[idx*DATAWIDTH +: DATAWIDTH];
                    la   = {{(ACCW - DATAWIDTH){la8[DATAWIDTH-1]}}, la8};
                    lb   = {{(ACCW - DATAWIDTH){lb8[DATAWIDTH-1]}}, lb8};
                    prod = la * lb;
                    unique case (op_q)
                        OpAdd: res_d[idx*DATAWIDTH +: DATAWIDTH] = sat_lane(la + lb);
                        OpSub: res_d[idx*DATAWIDTH +: DATAWIDTH] = sat_lane(la - lb);
                        OpMul: res_d[idx*DATAWIDTH +: DATAWIDTH] =
                                   sat_lane(prod >>> (DATAWIDTH - 1));
                        OpDot: dot_sum = dot_sum + prod;
                        default: ;
                    endcase
                end
                acc_sum = acc_q + dot_sum;
                acc_d   = acc_sum;
                k_d     = k_q + KW'(1);
                if (k_q == K_LAST) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    // Reduction lands in lane 0; other lanes stay cleared.
                    if (op_q == OpDot) begin
                        res_d[DATAWIDTH-1:0] = sat_lane(acc_sum >>> (DATAWIDTH - 1));
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset that discards any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpAdd;
            dst_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            dst_q       <= dst_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign wd3       = res_q;
    assign ra3       = dst_q;
    assign we3       = out_valid_q & out_ready;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed self-checking bench for vec_alu_seq with hand-computed vectors.
module tb_vec_alu_seq;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DOT = 2'b11;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [4:0]   dst;
    logic [127:0] srca;
    logic [127:0] srcb;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] wd3;
    logic [4:0]   ra3;
    logic         we3;

    int total;
    int bad;

    vec_alu_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dst       (dst),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wd3       (wd3),
        .ra3       (ra3),
        .we3       (we3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle, then scramble the inputs after acceptance.
    task automatic accept_op(input logic [1:0] o, input logic [4:0] d,
                             input logic [127:0] a, input logic [127:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        dst      = d;
        srca     = a;
        srcb     = b;
        check_eq("in_ready_pre", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        srca     = ~a;
        srcb     = ~b;
        op       = ~o;
        dst      = ~d;
    endtask

    // Called at the negedge after the accept edge.
    task automatic expect_result(input string tag, input logic [127:0] exp_wd,
                                 input logic [4:0] exp_ra);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_lat"}, out_valid, (i == 4) ? 1'b1 : 1'b0);
        end
        check_eq({tag, "_wd3"}, wd3, exp_wd);
        check_eq({tag, "_ra3"}, ra3, exp_ra);
        check_eq({tag, "_busy"}, in_ready, 1'b0);
    endtask

    // With out_ready high in DONE: one we3 pulse, then idle.
    task automatic finish_wb(input string tag);
        #1;
        check_eq({tag, "_we3"}, we3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_ov_low"}, out_valid, 1'b0);
        check_eq({tag, "_we3_low"}, we3, 1'b0);
        check_eq({tag, "_idle"}, in_ready, 1'b1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = OP_ADD;
        dst       = '0;
        srca      = '0;
        srcb      = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_ov", out_valid, 1'b0);
        check_eq("rst_ir", in_ready, 1'b1);
        check_eq("rst_we3", we3, 1'b0);
        check_eq("rst_wd3", wd3, 128'h0);
        check_eq("rst_ra3", ra3, 5'd0);

        // Reset in the middle of COMPUTE
        accept_op(OP_ADD, 5'd9, {16{8'h11}}, {16{8'h22}});
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_ov", out_valid, 1'b0);
        check_eq("midrst_ir", in_ready, 1'b1);
        check_eq("midrst_wd3", wd3, 128'h0);
        check_eq("midrst_ra3", ra3, 5'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("midrst_no_we3", we3, 1'b0);
        end

        // VADD positive saturation
        accept_op(OP_ADD, 5'd3, {16{8'h7F}}, {16{8'h01}});
        expect_result("vadd", {16{8'h7F}}, 5'd3);
        finish_wb("vadd");

        // VADD negative saturation
        accept_op(OP_ADD, 5'd4, {16{8'h80}}, {16{8'h80}});
        expect_result("vadd_neg", {16{8'h80}}, 5'd4);
        finish_wb("vadd_neg");

        // VSUB: lane0 -128-1 saturates, lane1 16-32 = -16
        accept_op(OP_SUB, 5'd1, 128'h1080, 128'h2001);
        expect_result("vsub", 128'hF080, 5'd1);
        finish_wb("vsub");

        // VMUL: 0.5*0.5, -1*-1 (saturates), -0.5*0.5
        accept_op(OP_MUL, 5'd2, 128'hC08040, 128'h408040);
        expect_result("vmul", 128'hE07F20, 5'd2);
        finish_wb("vmul");

        // VDOT: acc=65536 saturates
        accept_op(OP_DOT, 5'd10, {16{8'h40}}, {16{8'h40}});
        expect_result("vdot_sat", 128'h7F, 5'd10);
        finish_wb("vdot_sat");

        // VDOT: acc=1024 -> 8
        accept_op(OP_DOT, 5'd11, {16{8'h08}}, {16{8'h08}});
        expect_result("vdot", 128'h08, 5'd11);
        finish_wb("vdot");

        // VDOT: acc=-260096 saturates negative
        accept_op(OP_DOT, 5'd12, {16{8'h80}}, {16{8'h7F}});
        expect_result("vdot_neg", 128'h80, 5'd12);
        finish_wb("vdot_neg");

        // Backpressure with inputs changing mid-compute and a waiting request
        out_ready = 1'b0;
        accept_op(OP_MUL, 5'd5, 128'hC08040, 128'h408040);
        expect_result("bp", 128'hE07F20, 5'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                in_valid = 1'b1;
                op       = OP_ADD;
                dst      = 5'd7;
                srca     = {16{8'h7F}};
                srcb     = {16{8'h01}};
            end
            #1;
            check_eq("bp_ov", out_valid, 1'b1);
            check_eq("bp_wd3", wd3, 128'hE07F20);
            check_eq("bp_ir", in_ready, 1'b0);
            check_eq("bp_we3", we3, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check_eq("bp_rel_we3", we3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_rel_ir", in_ready, 1'b1);
        check_eq("bp_rel_ov", out_valid, 1'b0);
        check_eq("bp_rel_we3_low", we3, 1'b0);
        // Waiting request is accepted at the next edge
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        srca     = '0;
        op       = OP_SUB;
        expect_result("b2b", {16{8'h7F}}, 5'd7);
        finish_wb("b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
